// File: rtl/lcd_rx_pkg.sv
// Shared types and field widths for the LCD horizontal-timing receiver.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package lcd_rx_pkg;

   // Horizontal phase of the line currently being observed
   typedef enum logic [2:0] {
      PH_IDLE,
      PH_SYNC,
      PH_BP,
      PH_ACT,
      PH_FP
   } phase_t;

   localparam int unsigned PIX_PER_PPL = 16;  // pixels represented by one PPL step
   localparam int          HFIELD_W    = 8;   // HSW/HBP/HFP register width
   localparam int          PPL_W       = 6;   // PPL register width

   // PPL register encoding: groups of 16 pixels minus one, truncated to the field
   function automatic logic [PPL_W-1:0] ppl_code(input logic [31:0] pix);
      logic [31:0] groups;
      groups = (pix / PIX_PER_PPL) - 32'd1;
      return groups[PPL_W-1:0];
   endfunction

   // A line whose active width is not a whole number of PPL groups cannot be encoded exactly
   function automatic logic ppl_misaligned(input logic [31:0] pix);
      return (pix % PIX_PER_PPL) != 32'd0;
   endfunction

endpackage

// File: rtl/lcd_edge_det.sv
// Registers one panel input and flags its rising edge.
// Latency: q is one HCLK behind din; rise is combinational from q and its previous sample.
// Backpressure: none; free-running observer.
module lcd_edge_det (
   input  logic HCLK,
   input  logic HRESET,
   input  logic din,
   output logic q,
   output logic rise
);

   logic       q_prev;
   logic [1:0] armed;  // armed[1] means q_prev holds a real post-reset sample

   // Sample the input and keep one cycle of history; a level already high at reset is not an edge
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         q      <= 1'b0;
         q_prev <= 1'b0;
         armed  <= 2'b00;
      end else begin
         q      <= din;
         q_prev <= q;
         armed  <= {armed[0], 1'b1};
      end
   end

   assign rise = armed[1] & q & ~q_prev;

endmodule

// File: rtl/lcd_timing_rx.sv
// Measures LCD horizontal timing: DCLK divider, HSW/HBP/PPL/HFP and line length in HCLK.
// Latency: line_valid and results appear two HCLK after the closing lp edge reaches the pins.
// Backpressure: none; observe-only, each published line overwrites the previous one.
module lcd_timing_rx
   import lcd_rx_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int DIV_W = 10
) (
   input  logic                HCLK,
   input  logic                HRESET,
   input  logic                lcd_dclk,
   input  logic                lcd_lp,
   input  logic                lcd_enab,
   output logic [DIV_W-1:0]    meas_clkdiv,
   output logic [HFIELD_W-1:0] meas_hsw,
   output logic [HFIELD_W-1:0] meas_hbp,
   output logic [HFIELD_W-1:0] meas_hfp,
   output logic [PPL_W-1:0]    meas_ppl,
   output logic [CNT_W-1:0]    line_hclk,
   output logic                line_valid,
   output logic                err_seq,
   output logic                err_ppl,
   output logic                err_ovf
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Counters stick at all-ones so an overlong phase is still visible as a saturated value
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   logic             dclk_q, dclk_rise;
   logic             lp_q, lp_rise;
   logic             enab_q, enab_rise;
   logic             unused_ok;

   phase_t           state, state_nxt;
   logic [CNT_W-1:0] per_cnt, line_cnt;
   logic [CNT_W-1:0] sync_cnt, bp_cnt, act_cnt, fp_cnt;
   logic [CNT_W-1:0] sync_nxt, bp_nxt, act_nxt, fp_nxt;
   logic             line_bad;   // current line already broke sequence; do not publish it
   logic             publish, seq_err, mark_bad;

   lcd_edge_det u_dclk (.HCLK(HCLK), .HRESET(HRESET), .din(lcd_dclk), .q(dclk_q), .rise(dclk_rise));
   lcd_edge_det u_lp   (.HCLK(HCLK), .HRESET(HRESET), .din(lcd_lp),   .q(lp_q),   .rise(lp_rise));
   lcd_edge_det u_enab (.HCLK(HCLK), .HRESET(HRESET), .din(lcd_enab), .q(enab_q), .rise(enab_rise));

   // Edge outputs this block does not consume
   assign unused_ok = &{1'b0, dclk_q, enab_rise};

   // Phase decisions: a line edge always wins over a coincident DCLK and opens a new SYNC
   always_comb begin
      state_nxt = state;
      sync_nxt  = sync_cnt;
      bp_nxt    = bp_cnt;
      act_nxt   = act_cnt;
      fp_nxt    = fp_cnt;
      publish   = 1'b0;
      seq_err   = 1'b0;
      mark_bad  = 1'b0;
      if (lp_rise) begin
         state_nxt = PH_SYNC;
         sync_nxt  = dclk_rise ? CNT_ONE : '0;
         bp_nxt    = '0;
         act_nxt   = '0;
         fp_nxt    = '0;
         case (state)
            PH_BP, PH_ACT: seq_err = 1'b1;
            PH_FP:         publish = ~line_bad;
            default:       ;
         endcase
      end else if (dclk_rise) begin
         case (state)
            PH_SYNC: begin
               if (enab_q) begin
                  seq_err  = 1'b1;
                  mark_bad = 1'b1;
                  sync_nxt = CNT_ONE;
                  bp_nxt   = '0;
                  act_nxt  = '0;
                  fp_nxt   = '0;
               end else if (!lp_q) begin
                  state_nxt = PH_BP;
                  bp_nxt    = CNT_ONE;
               end else begin
                  sync_nxt = sat_inc(sync_cnt);
               end
            end
            PH_BP: begin
               if (enab_q) begin
                  state_nxt = PH_ACT;
                  act_nxt   = CNT_ONE;
               end else begin
                  bp_nxt = sat_inc(bp_cnt);
               end
            end
            PH_ACT: begin
               if (!enab_q) begin
                  state_nxt = PH_FP;
                  fp_nxt    = CNT_ONE;
               end else begin
                  act_nxt = sat_inc(act_cnt);
               end
            end
            PH_FP:   fp_nxt = sat_inc(fp_cnt);
            default: ;
         endcase
      end
   end

   // Phase state, phase counters and the discard flag for a broken line
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state    <= PH_IDLE;
         sync_cnt <= '0;
         bp_cnt   <= '0;
         act_cnt  <= '0;
         fp_cnt   <= '0;
         line_bad <= 1'b0;
      end else begin
         state    <= state_nxt;
         sync_cnt <= sync_nxt;
         bp_cnt   <= bp_nxt;
         act_cnt  <= act_nxt;
         fp_cnt   <= fp_nxt;
         if (lp_rise) begin
            line_bad <= 1'b0;
         end else if (mark_bad) begin
            line_bad <= 1'b1;
         end
      end
   end

   // DCLK period in HCLK; a period is only reported once two rises have been seen
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         per_cnt     <= '0;
         meas_clkdiv <= '0;
      end else if (dclk_rise) begin
         per_cnt <= CNT_ONE;
         if (per_cnt != '0) begin
            meas_clkdiv <= DIV_W'(per_cnt - CNT_ONE);
         end
      end else if (per_cnt != '0) begin
         per_cnt <= sat_inc(per_cnt);
      end
   end

   // HCLK cycles since the last line edge; idle until the first edge after reset
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         line_cnt <= '0;
      end else if (lp_rise) begin
         line_cnt <= CNT_ONE;
      end else if (state != PH_IDLE) begin
         line_cnt <= sat_inc(line_cnt);
      end
   end

   // Latch the finished line's results together with a one-cycle valid strobe
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         meas_hsw   <= '0;
         meas_hbp   <= '0;
         meas_hfp   <= '0;
         meas_ppl   <= '0;
         line_hclk  <= '0;
         line_valid <= 1'b0;
      end else begin
         line_valid <= publish;
         if (publish) begin
            meas_hsw  <= HFIELD_W'(sync_cnt - CNT_ONE);
            meas_hbp  <= HFIELD_W'(bp_cnt - CNT_ONE);
            meas_hfp  <= HFIELD_W'(fp_cnt - CNT_ONE);
            meas_ppl  <= ppl_code(32'(act_cnt));
            line_hclk <= line_cnt;
         end
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         err_seq <= 1'b0;
         err_ppl <= 1'b0;
         err_ovf <= 1'b0;
      end else begin
         err_seq <= err_seq | seq_err;
         err_ppl <= err_ppl | (publish & ppl_misaligned(32'(act_cnt)));
         err_ovf <= err_ovf | (&per_cnt) | (&line_cnt) | (&sync_cnt)
                            | (&bp_cnt) | (&act_cnt) | (&fp_cnt);
      end
   end

endmodule

// File: tb/tb_lcd_timing_rx.sv
// Directed bench for lcd_timing_rx: stimulus pushes expected line results, a monitor checks them.
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_timing_rx;

   localparam int CNT_W = 16;
   localparam int DIV_W = 10;
   localparam int STALL = 65536;

   logic             HCLK     = 1'b0;
   logic             HRESET   = 1'b1;
   logic             lcd_dclk = 1'b0;
   logic             lcd_lp   = 1'b0;
   logic             lcd_enab = 1'b0;
   logic [DIV_W-1:0] meas_clkdiv;
   logic [7:0]       meas_hsw, meas_hbp, meas_hfp;
   logic [5:0]       meas_ppl;
   logic [CNT_W-1:0] line_hclk;
   logic             line_valid, err_seq, err_ppl, err_ovf;

   typedef struct {
      logic [DIV_W-1:0] clkdiv;
      logic [7:0]       hsw;
      logic [7:0]       hbp;
      logic [5:0]       ppl;
      logic [7:0]       hfp;
      logic [CNT_W-1:0] lhclk;
      logic             eseq;
      logic             eppl;
      logic             eovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   logic x_seq = 1'b0;
   logic x_ppl = 1'b0;
   logic x_ovf = 1'b0;

   lcd_timing_rx #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .lcd_dclk(lcd_dclk), .lcd_lp(lcd_lp), .lcd_enab(lcd_enab),
      .meas_clkdiv(meas_clkdiv), .meas_hsw(meas_hsw), .meas_hbp(meas_hbp), .meas_hfp(meas_hfp),
      .meas_ppl(meas_ppl), .line_hclk(line_hclk), .line_valid(line_valid),
      .err_seq(err_seq), .err_ppl(err_ppl), .err_ovf(err_ovf)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   // One DCLK period; lp/enab change together with the DCLK rising level, as a panel drives them
   task automatic dclk_cyc(input logic lp, input logic en, input int per);
      lcd_dclk = 1'b1;
      lcd_lp   = lp;
      lcd_enab = en;
      step(per / 2);
      lcd_dclk = 1'b0;
      step(per - per / 2);
   endtask

   // One line; en_sync_at >= 0 raises enab on that SYNC DCLK, stall_fp > 0 freezes DCLK after that FP DCLK
   task automatic send_line(input int s, input int b, input int a, input int f, input int per,
                            input int en_sync_at, input int stall_fp);
      for (int i = 0; i < s; i++) dclk_cyc(1'b1, (i == en_sync_at), per);
      for (int i = 0; i < b; i++) dclk_cyc(1'b0, 1'b0, per);
      for (int i = 0; i < a; i++) dclk_cyc(1'b0, 1'b1, per);
      for (int i = 0; i < f; i++) begin
         dclk_cyc(1'b0, 1'b0, per);
         if (i + 1 == stall_fp) step(STALL);
      end
   endtask

   task automatic push_exp(input int cd, input int hsw, input int hbp, input int ppl,
                           input int hfp, input int lh);
      exp_t e;
      e.clkdiv = DIV_W'(cd);
      e.hsw    = 8'(hsw);
      e.hbp    = 8'(hbp);
      e.ppl    = 6'(ppl);
      e.hfp    = 8'(hfp);
      e.lhclk  = CNT_W'(lh);
      e.eseq   = x_seq;
      e.eppl   = x_ppl;
      e.eovf   = x_ovf;
      exp_q.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_clkdiv"}, 32'(meas_clkdiv), 32'd0);
      check({tag, "_hsw"},    32'(meas_hsw),    32'd0);
      check({tag, "_hbp"},    32'(meas_hbp),    32'd0);
      check({tag, "_hfp"},    32'(meas_hfp),    32'd0);
      check({tag, "_ppl"},    32'(meas_ppl),    32'd0);
      check({tag, "_lhclk"},  32'(line_hclk),   32'd0);
      check({tag, "_valid"},  32'(line_valid),  32'd0);
      check({tag, "_errs"},   32'({err_seq, err_ppl, err_ovf}), 32'd0);
   endtask

   // Monitor: every line_valid pulse must match the oldest expected line
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge HCLK);
         if (line_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_line_valid: got 1, want 0");
            end else begin
               e = exp_q.pop_front();
               check("line_clkdiv",  32'(meas_clkdiv), 32'(e.clkdiv));
               check("line_hsw",     32'(meas_hsw),    32'(e.hsw));
               check("line_hbp",     32'(meas_hbp),    32'(e.hbp));
               check("line_ppl",     32'(meas_ppl),    32'(e.ppl));
               check("line_hfp",     32'(meas_hfp),    32'(e.hfp));
               check("line_hclk",    32'(line_hclk),   32'(e.lhclk));
               check("line_err_seq", 32'(err_seq),     32'(e.eseq));
               check("line_err_ppl", 32'(err_ppl),     32'(e.eppl));
               check("line_err_ovf", 32'(err_ovf),     32'(e.eovf));
            end
         end
      end
   end

   initial begin : stimulus
      step(3);
      check_all_zero("reset");
      HRESET = 1'b0;
      step(4);

      // L0: first edge only starts measurement
      send_line(3, 5, 32, 7, 4, -1, 0);
      push_exp(3, 2, 4, 1, 6, 188);
      // L1: 30 active pixels -> ppl truncated to 0, err_ppl
      send_line(3, 5, 30, 7, 4, -1, 0);
      x_ppl = 1'b1;
      push_exp(3, 2, 4, 0, 6, 180);
      // L2: enab during SYNC -> discarded
      send_line(3, 5, 32, 7, 4, 1, 0);
      x_seq = 1'b1;
      check("err_seq_after_sync_enab", 32'(err_seq), 32'd1);
      // L3: clean line after the broken one
      send_line(3, 5, 32, 7, 4, -1, 0);
      push_exp(3, 2, 4, 1, 6, 188);
      // L4: DCLK period drops to 2 HCLK
      send_line(3, 5, 32, 7, 2, -1, 0);
      check("clkdiv_fast", 32'(meas_clkdiv), 32'd1);
      push_exp(1, 2, 4, 1, 6, 94);
      // L5: DCLK frozen in FP long enough to saturate the line counter
      send_line(3, 5, 32, 7, 4, -1, 3);
      x_ovf = 1'b1;
      check("err_ovf_after_stall", 32'(err_ovf), 32'd1);
      push_exp(3, 2, 4, 1, 6, 32'hFFFF);

      // L6: reset in the middle of ACT
      for (int i = 0; i < 3; i++) dclk_cyc(1'b1, 1'b0, 4);
      for (int i = 0; i < 5; i++) dclk_cyc(1'b0, 1'b0, 4);
      for (int i = 0; i < 10; i++) dclk_cyc(1'b0, 1'b1, 4);
      HRESET = 1'b1;
      #1;
      check_all_zero("midact_reset");
      step(3);
      HRESET = 1'b0;
      x_seq = 1'b0;
      x_ppl = 1'b0;
      x_ovf = 1'b0;
      for (int i = 0; i < 22; i++) dclk_cyc(1'b0, 1'b1, 4);
      for (int i = 0; i < 7; i++) dclk_cyc(1'b0, 1'b0, 4);
      // L7: first edge after reset starts measurement, the next one publishes
      send_line(3, 5, 32, 7, 4, -1, 0);
      push_exp(3, 2, 4, 1, 6, 188);
      dclk_cyc(1'b1, 1'b0, 4);
      step(20);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/lcd_timing_rx.md
LCD_TIMING_RX -- requirements
Module: lcd_timing_rx

Interface
REQ-001 Parameter CNT_W, default 16: width of every internal phase counter and of line_hclk.
REQ-002 Parameter DIV_W, default 10: width of meas_clkdiv.
REQ-003 HCLK  input  1  system clock; all logic is on its rising edge.
REQ-004 HRESET  input  1  reset, asynchronous assert, active-high.
REQ-005 lcd_dclk  input  1  panel pixel clock, synchronous to HCLK.
REQ-006 lcd_lp  input  1  line pulse, active-high (HSW phase).
REQ-007 lcd_enab  input  1  data enable, high during active pixels.
REQ-008 meas_clkdiv  output  DIV_W  measured CLKDIV (DCLK period in HCLK cycles minus 1).
REQ-009 meas_hsw, meas_hbp, meas_hfp  output  8 each  measured HSW/HBP/HFP register values (DCLK count minus 1).
REQ-010 meas_ppl  output  6  measured PPL value (active pixels/16 minus 1).
REQ-011 line_hclk  output  CNT_W  HCLK cycles from one lcd_lp rise to the next.
REQ-012 line_valid  output  1  one-HCLK pulse when the meas_* outputs and line_hclk update.
REQ-013 err_seq, err_ppl, err_ovf  output  1 each  sticky error flags, cleared only by reset.

Function
REQ-014 The block registers all three inputs once. It detects rising edges (dclk_rise, lp_rise) from the registered value and its previous value.
REQ-015 Period counter: counts HCLK cycles between consecutive dclk_rise. On each dclk_rise, meas_clkdiv <= count-1 and the counter restarts at 1.
REQ-016 Phase FSM states: IDLE, SYNC, BP, ACT, FP. The FSM advances only on dclk_rise, except where REQ-020 applies.
REQ-017 IDLE->SYNC on dclk_rise with lcd_lp=1 following lcd_lp=0 (the first line edge after reset is never measured).
REQ-018 SYNC: count DCLKs; ->BP when lcd_lp=0.
REQ-019 BP: count DCLKs; ->ACT when lcd_enab=1. ACT: count pixels; ->FP when lcd_enab=0.
REQ-020 FP: count DCLKs; on lp_rise, publish the results, pulse line_valid one cycle later, then ->SYNC with all phase counters reset to 1.
REQ-021 Published values: hsw=sync_cnt-1, hbp=bp_cnt-1, ppl=act_cnt/16-1, hfp=fp_cnt-1, line_hclk=HCLK count between lp rises. Subtraction is truncated to the output width.
REQ-022 Errors on the published line:
  - act_cnt mod 16 != 0 sets err_ppl; ppl is still published, truncated.
  - lcd_enab=1 while in SYNC, or lp_rise in BP/ACT, sets err_seq and forces ->SYNC with no publish.
REQ-023 Any counter that reaches all-ones saturates and sets err_ovf; the line is still published with the saturated value.
REQ-024 dclk_rise and lp_rise in the same cycle: lp_rise is treated as the phase boundary, and that DCLK is counted in the new SYNC phase.
REQ-025 Outputs hold their last published values between line_valid pulses.

Reset
REQ-026 HRESET=1 drives the following asynchronously: FSM=IDLE, all counters=0, meas_*=0, line_hclk=0, line_valid=0, err_*=0.
REQ-027 Reset mid-line discards the partial line; the first line_valid after reset requires two lp_rise events.

Structure
REQ-028 A shared package lcd_rx_pkg holds the phase-state enum, PIX_PER_PPL=16, and the field widths (8, 6).
REQ-029 One sub-module, lcd_edge_det (registered input plus rise detect), is instantiated three times. The FSM and counters stay in the top level.

Verification
REQ-030 DCLK period 4 HCLK, 3 sync, 5 BP, 32 active, 7 FP DCLKs -> second lp_rise gives line_valid=1 with clkdiv=3, hsw=2, hbp=4, ppl=1, hfp=6, line_hclk=188.
REQ-031 Same line with 30 active pixels -> err_ppl=1, ppl=0, line_valid still pulses.
REQ-032 lcd_enab raised during SYNC -> err_seq=1, no line_valid for that line, and the next clean line publishes correctly.
REQ-033 HRESET asserted mid-ACT -> all outputs 0 immediately; line_valid first pulses at the second lp_rise after release.
REQ-034 Constant lcd_dclk=0 for 2^16 HCLK within a line -> err_ovf=1, and line_hclk saturates at 16'hFFFF.
REQ-035 DCLK period changed from 4 to 2 HCLK mid-stream -> meas_clkdiv reads 1 after the second rise at the new rate.
